// File: rtl/jt12_pkg.sv
// Shared constants and types for the FM core's LFO: divider table, phase/AM widths
// and the helpers that turn a frequency select into a limit and a phase into an AM level.
package jt12_pkg;

    localparam int LFO_W = 7;
    localparam int AM_W  = 6;

    typedef logic [LFO_W-1:0] lfo_phase_t;
    typedef logic [AM_W-1:0]  lfo_am_t;

    // Samples per LFO step, indexed by the 3-bit frequency select
    localparam lfo_phase_t LFO_DIV [8] = '{
        7'd108, 7'd77, 7'd71, 7'd67, 7'd62, 7'd44, 7'd8, 7'd5
    };

    function automatic lfo_phase_t lfo_limit(input logic [2:0] freq);
        return LFO_DIV[freq] - 7'd1;
    endfunction

    // Triangle: phases 0..63 fall 63..0, phases 64..127 rise 0..63
    function automatic lfo_am_t lfo_am_map(input lfo_phase_t ph);
        return ph[LFO_W-1] ? ph[AM_W-1:0] : ~ph[AM_W-1:0];
    endfunction

endpackage

// File: rtl/jt12_lfo_if.sv
// Signal bundle between the register/timing side of the FM core and the LFO.
interface jt12_lfo_if;
    import jt12_pkg::*;

    logic       clk_en;
    logic       zero;
    logic       lfo_en;
    logic [2:0] lfo_freq;
    lfo_phase_t lfo_mod;
    lfo_am_t    lfo_am;
    logic       lfo_step;

    modport master (
        output clk_en, zero, lfo_en, lfo_freq,
        input  lfo_mod, lfo_am, lfo_step
    );

    modport slave (
        input  clk_en, zero, lfo_en, lfo_freq,
        output lfo_mod, lfo_am, lfo_step
    );

endinterface

// File: rtl/jt12_lfo_div.sv
// Sample divider: counts zero markers and ticks once the live limit is reached.
// The compare is >= so a lowered frequency select fires on the very next marker.
module jt12_lfo_div
    import jt12_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en_i,
    input  logic       clr_i,
    input  logic       zero_i,
    input  logic [2:0] freq_i,
    output logic       tick_o
);

    lfo_phase_t cnt_q, cnt_d;
    logic       hit;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        hit    = (cnt_q >= lfo_limit(freq_i));
        if (clk_en_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (zero_i) begin
                if (hit) begin
                    cnt_d  = '0;
                    tick_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jt12_lfo.sv
// LFO top: phase register advanced by the divider tick, step pulse and AM triangle.
// Disabling the LFO clears phase and divider synchronously and holds them at zero.
module jt12_lfo
    import jt12_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    jt12_lfo_if.slave  bus
);

    lfo_phase_t mod_q, mod_d;
    logic       step_q, step_d;
    logic       tick;
    logic       div_clr;

    assign div_clr = ~bus.lfo_en;

    jt12_lfo_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en_i (bus.clk_en),
        .clr_i    (div_clr),
        .zero_i   (bus.zero),
        .freq_i   (bus.lfo_freq),
        .tick_o   (tick)
    );

    always_comb begin
        mod_d  = mod_q;
        step_d = step_q;
        // The step pulse only moves on clk_en cycles, so it spans exactly one of them
        if (bus.clk_en) begin
            step_d = tick;
            if (!bus.lfo_en) begin
                mod_d = '0;
            end else if (tick) begin
                mod_d = mod_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mod_q  <= '0;
            step_q <= 1'b0;
        end else begin
            mod_q  <= mod_d;
            step_q <= step_d;
        end
    end

    assign bus.lfo_mod  = mod_q;
    assign bus.lfo_step = step_q;
    assign bus.lfo_am   = lfo_am_map(mod_q);

endmodule

// File: tb/tb_jt12_lfo.sv
// Directed bench for jt12_lfo: stepping, wrap, live frequency change, enable clear,
// clock-enable hold and reset while the clock enable is low.
module tb_jt12_lfo;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_steps;
    int   step_seen;

    jt12_lfo_if bus ();

    jt12_lfo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clk_en cycle with zero high; afterwards zero is low and clk_en stays high
    task automatic pulse();
        @(negedge clk);
        bus.clk_en = 1'b1;
        bus.zero   = 1'b1;
        @(negedge clk);
        step_seen = int'(bus.lfo_step);
        if (bus.lfo_step) n_steps++;
        bus.zero = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_steps      = 0;
        step_seen    = 0;
        rst_n        = 1'b0;
        bus.clk_en   = 1'b1;
        bus.zero     = 1'b0;
        bus.lfo_en   = 1'b0;
        bus.lfo_freq = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_mod", int'(bus.lfo_mod), 0);
        check("rst_am", int'(bus.lfo_am), 63);
        check("rst_step", int'(bus.lfo_step), 0);

        // freq 7: five markers per step
        bus.lfo_en   = 1'b1;
        bus.lfo_freq = 3'd7;
        run(4);
        check("f7_early_steps", n_steps, 0);
        check("f7_early_mod", int'(bus.lfo_mod), 0);
        pulse();
        check("f7_step5", step_seen, 1);
        check("f7_mod", int'(bus.lfo_mod), 1);
        check("f7_am", int'(bus.lfo_am), 62);
        @(negedge clk);
        check("f7_step_one_cycle", int'(bus.lfo_step), 0);
        check("f7_steps", n_steps, 1);

        // Clear via enable, then full wrap at freq 6 (8 markers per step)
        @(negedge clk);
        bus.lfo_en = 1'b0;
        @(negedge clk);
        bus.lfo_en = 1'b1;
        check("clr_mod", int'(bus.lfo_mod), 0);
        bus.lfo_freq = 3'd6;
        n_steps      = 0;
        for (int i = 0; i < 1024; i++) begin
            pulse();
            if (i == 511) begin
                check("f6_mod64", int'(bus.lfo_mod), 64);
                check("f6_am64", int'(bus.lfo_am), 0);
            end
            if (i == 1015) begin
                check("f6_mod127", int'(bus.lfo_mod), 127);
                check("f6_am127", int'(bus.lfo_am), 63);
            end
        end
        check("f6_steps", n_steps, 128);
        check("f6_wrap_mod", int'(bus.lfo_mod), 0);
        check("f6_wrap_am", int'(bus.lfo_am), 63);

        // Count 50 at freq 0, then drop to freq 7: next marker must step
        bus.lfo_freq = 3'd0;
        n_steps      = 0;
        run(50);
        check("f0_no_step", n_steps, 0);
        bus.lfo_freq = 3'd7;
        pulse();
        check("drop_step", step_seen, 1);
        check("drop_mod", int'(bus.lfo_mod), 1);
        n_steps = 0;
        run(4);
        check("drop_cnt_reset", n_steps, 0);
        pulse();
        check("drop_next_mod", int'(bus.lfo_mod), 2);

        // Reach 37, leave a partial count, disable for one clk_en cycle
        run(175);
        check("mod37", int'(bus.lfo_mod), 37);
        run(3);
        @(negedge clk);
        bus.lfo_en = 1'b0;
        @(negedge clk);
        bus.lfo_en = 1'b1;
        check("dis_mod", int'(bus.lfo_mod), 0);
        check("dis_am", int'(bus.lfo_am), 63);
        n_steps = 0;
        run(4);
        check("reen_early", n_steps, 0);
        pulse();
        check("reen_step5", step_seen, 1);
        check("reen_mod", int'(bus.lfo_mod), 1);

        // clk_en low for 100 clks with zero toggling: everything holds
        run(4);
        pulse();
        bus.clk_en = 1'b0;
        check("hold_pre_step", int'(bus.lfo_step), 1);
        check("hold_pre_mod", int'(bus.lfo_mod), 2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.zero     = (i % 2 == 0);
            bus.lfo_freq = (i % 3 == 0) ? 3'd6 : 3'd7;
        end
        check("hold_step", int'(bus.lfo_step), 1);
        check("hold_mod", int'(bus.lfo_mod), 2);
        bus.zero     = 1'b0;
        bus.lfo_freq = 3'd7;
        bus.clk_en   = 1'b1;
        @(negedge clk);
        check("hold_release_step", int'(bus.lfo_step), 0);
        check("hold_release_mod", int'(bus.lfo_mod), 2);
        n_steps = 0;
        run(4);
        check("hold_no_count", n_steps, 0);
        pulse();
        check("hold_next_mod", int'(bus.lfo_mod), 3);

        // Reach 90 with step high, then reset for one clk while clk_en is low
        run(435);
        bus.clk_en = 1'b0;
        check("mod90", int'(bus.lfo_mod), 90);
        check("mod90_step", int'(bus.lfo_step), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_mod", int'(bus.lfo_mod), 0);
        check("rst2_am", int'(bus.lfo_am), 63);
        check("rst2_step", int'(bus.lfo_step), 0);

        // Reset mid-count drops the partial count
        run(2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        n_steps = 0;
        run(4);
        check("rst3_no_resume", n_steps, 0);
        pulse();
        check("rst3_step5", step_seen, 1);
        check("rst3_mod", int'(bus.lfo_mod), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jt12_lfo.md
Name: jt12_lfo

Overview:
- Low-frequency oscillator for the FM core. Sits directly upstream of the phase generator.
- Produces the 7-bit LFO phase `lfo_mod` consumed by the PG (PM path, bits [6:2]) and a 6-bit AM triangle for the envelope stage.
- Steps once per N output samples, where N comes from the LFO frequency register, and is timed by the slot-0 `zero` marker.

Parameters:
- None. The divider table is a fixed constant in the shared package.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- clk_en  in  1  clock enable; all state advances only when high (except reset)
- zero  in  1  sample marker; high for exactly one clk_en cycle per 24-slot sample
- lfo_en  in  1  LFO enable (register 0x22 bit 3)
- lfo_freq  in  3  frequency select (register 0x22 bits 2:0)
- lfo_mod  out  7  LFO phase to PG (`lfo_mod` input of PG)
- lfo_am  out  6  AM triangle to envelope generator
- lfo_step  out  1  one-clk_en-cycle pulse, high on the cycle `lfo_mod` increments

Behaviour:
- Reset, sampled on posedge clk regardless of clk_en:
  - rst_n=0 forces div_cnt=0, lfo_mod=0, lfo_step=0.
  - `lfo_am` is therefore 63 (see AM rule).
  - Reset asserted mid-count discards the partial count; there is no resume.
- Internal state:
  - div_cnt: 7-bit sample divider.
  - lfo_mod: 7-bit phase register.
- Divider limits L(lfo_freq), indices 0..7: 108, 77, 71, 67, 62, 44, 8, 5 samples per step.
- Each clk_en cycle with rst_n=1:
  - lfo_en=0: div_cnt<=0, lfo_mod<=0, lfo_step<=0. Synchronous clear; holds while disabled.
  - lfo_en=1 and zero=0: state held, lfo_step<=0.
  - lfo_en=1, zero=1, div_cnt >= L-1: div_cnt<=0, lfo_mod<=lfo_mod+1, lfo_step<=1.
    - `lfo_mod` wraps modulo 128 (127 -> 0).
  - lfo_en=1, zero=1, otherwise: div_cnt<=div_cnt+1, lfo_step<=0.
- Compare is >=, not ==. If lfo_freq drops so that div_cnt already exceeds the new L-1, the step fires on the very next zero pulse. There is no lockout and no 128-sample overrun.
- lfo_freq is used live. A change takes effect at the next zero evaluation; no shadow register.
- clk_en=0: every register holds, including lfo_step. The pulse lasts exactly one clk_en cycle.
- zero while lfo_en goes 0->1: the enable is evaluated in the same cycle. The first count occurs on that zero if lfo_en is already 1 in that cycle.
- Latency:
  - `lfo_mod` is registered and changes one clk edge after the qualifying zero/clk_en cycle.
  - `lfo_am` is combinational from the `lfo_mod` register, with no extra latency.
- AM rule: lfo_am = lfo_mod[6] ? lfo_mod[5:0] : ~lfo_mod[5:0].
  - 0..63 maps to 63..0; 64..127 maps to 0..63.
- Full PM period = 128*L samples (e.g. 640 samples at lfo_freq=7).
- Interface with PG: `lfo_mod` is constant across all 24 slots of a sample except at the update edge. The PG may sample it in any slot.

Decomposition:
- Shared package `jt12_pkg`:
  - LFO_DIV table, eight 7-bit constants: 108, 77, 71, 67, 62, 44, 8, 5.
  - Width constants LFO_W=7 and AM_W=6.
- One sub-module, `jt12_lfo_div`:
  - Holds the 7-bit divider counter with `>=` compare; outputs a tick.
  - Top level holds the phase register, the AM mapping and the enable clear.

Test Plan:
- Reset, then lfo_en=1, lfo_freq=7, 5 zero pulses: lfo_mod=1 and lfo_step pulsed once, on the 5th pulse only. lfo_am goes 63 -> 62.
- lfo_freq=6, 8*128=1024 zero pulses: lfo_mod returns to 0 (wrap). Exactly 128 lfo_step pulses. lfo_am=0 when lfo_mod=64.
- lfo_freq=0, 50 zero pulses (div_cnt=50), then switch lfo_freq=7: the next zero pulse steps lfo_mod to 1 and div_cnt returns to 0.
- Running with lfo_mod=37: deassert lfo_en for one clk_en cycle, giving lfo_mod=0 and div_cnt=0. Re-enable with lfo_freq=7: first step after 5 zero pulses.
- clk_en held low for 100 clks with zero toggling: no state change. lfo_step stays high if it was high, until the next clk_en cycle.
- rst_n=0 for one clk while clk_en=0 at lfo_mod=90: lfo_mod=0, lfo_am=63, lfo_step=0 on the next edge.
